// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two 2-deep result queues (ALU, MEM)
// drained round-robin into a registered one-result-per-cycle broadcast.
module cdb_fifo #(
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                clr,
  input  logic                push,
  input  logic                pop,
  input  logic [ROB_ID_W-1:0] wr_id,
  input  logic [DATA_W-1:0]   wr_value,
  output logic [ROB_ID_W-1:0] rd_id,
  output logic [DATA_W-1:0]   rd_value,
  output logic [1:0]          count
);

  logic [ROB_ID_W-1:0] id_q  [2];
  logic [DATA_W-1:0]   val_q [2];
  logic                wr_ptr;
  logic                rd_ptr;

  assign rd_id    = id_q[rd_ptr];
  assign rd_value = val_q[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Slot contents are only meaningful below count, so no reset here.
  always_ff @(posedge clk_in) begin
    if (push) begin
      id_q[wr_ptr]  <= wr_id;
      val_q[wr_ptr] <= wr_value;
    end
  end

endmodule

module cdb_arbiter #(
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_pipline,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ROB_ID_W-1:0] mem_rob_id,
  input  logic [DATA_W-1:0]   mem_value,
  output logic                mem_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic [1:0]          alu_cnt;
  logic [1:0]          mem_cnt;
  logic [ROB_ID_W-1:0] alu_hd_id;
  logic [ROB_ID_W-1:0] mem_hd_id;
  logic [DATA_W-1:0]   alu_hd_val;
  logic [DATA_W-1:0]   mem_hd_val;
  logic                last_grant;
  logic                active;
  logic                alu_push;
  logic                mem_push;
  logic                alu_ne;
  logic                mem_ne;
  logic                alu_gnt;
  logic                mem_gnt;

  assign active    = rdy_in & ~flush_pipline;
  assign alu_ready = rdy_in & (alu_cnt != 2'd2);
  assign mem_ready = rdy_in & (mem_cnt != 2'd2);
  assign alu_push  = alu_valid & alu_ready & ~flush_pipline;
  assign mem_push  = mem_valid & mem_ready & ~flush_pipline;
  assign alu_ne    = alu_cnt != 2'd0;
  assign mem_ne    = mem_cnt != 2'd0;

  // Only the registered count is seen, so a fresh push never pops
  // on the same edge: two edges minimum from accept to broadcast.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (active) begin
      alu_gnt = alu_ne & (~mem_ne | (last_grant == SRC_MEM));
      mem_gnt = mem_ne & (~alu_ne | (last_grant == SRC_ALU));
    end
  end

  cdb_fifo #(
    .ROB_ID_W (ROB_ID_W),
    .DATA_W   (DATA_W)
  ) u_alu_q (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr      (flush_pipline),
    .push     (alu_push),
    .pop      (alu_gnt),
    .wr_id    (alu_rob_id),
    .wr_value (alu_value),
    .rd_id    (alu_hd_id),
    .rd_value (alu_hd_val),
    .count    (alu_cnt)
  );

  cdb_fifo #(
    .ROB_ID_W (ROB_ID_W),
    .DATA_W   (DATA_W)
  ) u_mem_q (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr      (flush_pipline),
    .push     (mem_push),
    .pop      (mem_gnt),
    .wr_id    (mem_rob_id),
    .wr_value (mem_value),
    .rd_id    (mem_hd_id),
    .rd_value (mem_hd_val),
    .count    (mem_cnt)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= SRC_ALU;
      last_grant <= SRC_MEM;
    end else if (flush_pipline) begin
      cdb_valid  <= 1'b0;
      last_grant <= SRC_MEM;
    end else if (rdy_in) begin
      unique case (1'b1)
        alu_gnt: begin
          cdb_valid  <= 1'b1;
          cdb_rob_id <= alu_hd_id;
          cdb_value  <= alu_hd_val;
          cdb_src    <= SRC_ALU;
          last_grant <= SRC_ALU;
        end
        mem_gnt: begin
          cdb_valid  <= 1'b1;
          cdb_rob_id <= mem_hd_id;
          cdb_value  <= mem_hd_val;
          cdb_src    <= SRC_MEM;
          last_grant <= SRC_MEM;
        end
        default: cdb_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int IW = 5;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_pipline;
  logic          alu_valid;
  logic [IW-1:0] alu_rob_id;
  logic [DW-1:0] alu_value;
  logic          alu_ready;
  logic          mem_valid;
  logic [IW-1:0] mem_rob_id;
  logic [DW-1:0] mem_value;
  logic          mem_ready;
  logic          cdb_valid;
  logic [IW-1:0] cdb_rob_id;
  logic [DW-1:0] cdb_value;
  logic          cdb_src;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(
    .ROB_ID_W (IW),
    .DATA_W   (DW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_pipline (flush_pipline),
    .alu_valid     (alu_valid),
    .alu_rob_id    (alu_rob_id),
    .alu_value     (alu_value),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_rob_id    (mem_rob_id),
    .mem_value     (mem_value),
    .mem_ready     (mem_ready),
    .cdb_valid     (cdb_valid),
    .cdb_rob_id    (cdb_rob_id),
    .cdb_value     (cdb_value),
    .cdb_src       (cdb_src)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-source queues of {tag,value}
  logic [IW+DW-1:0] qa[$];
  logic [IW+DW-1:0] qm[$];
  logic             m_last = 1'b1;
  logic             m_v    = 1'b0;
  logic             m_src  = 1'b0;
  logic [IW-1:0]    m_id   = '0;
  logic [DW-1:0]    m_val  = '0;
  bit               m_init = 1'b0;
  int               tag_n  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ra;
    bit rm;
    bit ga;
    bit gm;
    logic [IW+DW-1:0] e;
    ra = rdy_in && (qa.size() < 2);
    rm = rdy_in && (qm.size() < 2);
    if (rst_in) begin
      qa.delete();
      qm.delete();
      m_v    = 1'b0;
      m_id   = '0;
      m_val  = '0;
      m_src  = 1'b0;
      m_last = 1'b1;
      m_init = 1'b1;
    end else if (flush_pipline) begin
      qa.delete();
      qm.delete();
      m_v    = 1'b0;
      m_last = 1'b1;
    end else if (rdy_in) begin
      ga = (qa.size() > 0) && ((qm.size() == 0) || m_last);
      gm = !ga && (qm.size() > 0);
      if (ga) begin
        e = qa.pop_front();
        {m_id, m_val} = e;
        m_src  = 1'b0;
        m_last = 1'b0;
        m_v    = 1'b1;
      end else if (gm) begin
        e = qm.pop_front();
        {m_id, m_val} = e;
        m_src  = 1'b1;
        m_last = 1'b1;
        m_v    = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      if (alu_valid && ra) qa.push_back({alu_rob_id, alu_value});
      if (mem_valid && rm) qm.push_back({mem_rob_id, mem_value});
    end
  endtask

  task automatic step();
    #1;
    if (m_init) begin
      chk("alu_ready", 64'(alu_ready), 64'(rdy_in && (qa.size() < 2)));
      chk("mem_ready", 64'(mem_ready), 64'(rdy_in && (qm.size() < 2)));
    end
    @(posedge clk_in);
    model_edge();
    #1;
    if (m_init) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
      if (m_v) begin
        chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
        chk("cdb_value", 64'(cdb_value), 64'(m_val));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
      end
    end
  endtask

  task automatic idle();
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    flush_pipline = 1'b0;
    alu_valid     = 1'b0;
    mem_valid     = 1'b0;
  endtask

  task automatic offer_a(input int t);
    alu_valid  = 1'b1;
    alu_rob_id = IW'(t);
    alu_value  = DW'(32'hA000 + t);
  endtask

  task automatic offer_m(input int t);
    mem_valid  = 1'b1;
    mem_rob_id = IW'(t);
    mem_value  = DW'(32'hB000 + t);
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      offer_a(tag_n);
      offer_m(tag_n + 1);
      tag_n = (tag_n + 2) % 32;
      step();
    end
  endtask

  initial begin
    bit seen_low;
    idle();
    alu_rob_id = '0;
    alu_value  = '0;
    mem_rob_id = '0;
    mem_value  = '0;

    // reset wins over flush and pause
    rst_in        = 1'b1;
    rdy_in        = 1'b0;
    flush_pipline = 1'b1;
    alu_valid     = 1'b1;
    step();
    step();
    chk("rst_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    idle();
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);

    // lone ALU result, two-edge latency
    offer_a(3);
    alu_value = 32'h11;
    step();
    idle();
    step();
    chk("lone_valid", 64'(cdb_valid), 64'd1);
    chk("lone_tag", 64'(cdb_rob_id), 64'd3);
    chk("lone_value", 64'(cdb_value), 64'h11);
    chk("lone_src", 64'(cdb_src), 64'd0);
    step();
    chk("lone_drop", 64'(cdb_valid), 64'd0);

    // ties after reset alternate ALU then MEM
    do_reset();
    for (int p = 0; p < 2; p++) begin
      idle();
      offer_a(1 + 2 * p);
      offer_m(2 + 2 * p);
      step();
      idle();
      step();
      chk("tie_tag_a", 64'(cdb_rob_id), 64'(1 + 2 * p));
      chk("tie_src_a", 64'(cdb_src), 64'd0);
      step();
      chk("tie_tag_m", 64'(cdb_rob_id), 64'(2 + 2 * p));
      chk("tie_src_m", 64'(cdb_src), 64'd1);
    end

    // backpressure: both sources offer every cycle
    seen_low = 1'b0;
    for (int i = 0; i < 24; i++) begin
      idle();
      offer_a(tag_n);
      offer_m(tag_n + 1);
      tag_n = (tag_n + 2) % 32;
      #1;
      if (!mem_ready) seen_low = 1'b1;
      step();
    end
    chk("bp_mem_ready_low", 64'(seen_low), 64'd1);
    idle();
    for (int i = 0; i < 4; i++) step();

    // pause with tag 5 on the bus
    do_reset();
    idle();
    offer_a(5);
    step();
    offer_a(6);
    step();
    chk("pause_pre", 64'(cdb_rob_id), 64'd5);
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_valid", 64'(cdb_valid), 64'd1);
      chk("pause_tag", 64'(cdb_rob_id), 64'd5);
      chk("pause_ready", 64'(alu_ready), 64'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("resume_tag", 64'(cdb_rob_id), 64'd6);
    chk("resume_valid", 64'(cdb_valid), 64'd1);

    // flush with queued entries and a same-cycle offer
    fill(5);
    idle();
    flush_pipline = 1'b1;
    offer_a(30);
    step();
    idle();
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    #1;
    chk("flush_alu_ready", 64'(alu_ready), 64'd1);
    chk("flush_mem_ready", 64'(mem_ready), 64'd1);
    for (int i = 0; i < 4; i++) step();

    // reset mid-operation while paused
    fill(5);
    idle();
    rdy_in = 1'b0;
    rst_in = 1'b1;
    step();
    chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_tag", 64'(cdb_rob_id), 64'd0);
    chk("mid_rst_value", 64'(cdb_value), 64'd0);
    chk("mid_rst_src", 64'(cdb_src), 64'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst_in        = ($urandom_range(0, 199) == 0);
      flush_pipline = ($urandom_range(0, 39) == 0);
      rdy_in        = ($urandom_range(0, 7) != 0);
      alu_valid     = ($urandom_range(0, 9) < 7);
      mem_valid     = ($urandom_range(0, 9) < 6);
      alu_rob_id    = IW'($urandom);
      alu_value     = $urandom;
      mem_rob_id    = IW'($urandom);
      mem_value     = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter ROB_ID_W, default 5, the instruction/ROB tag width.
REQ-002 SHALL have parameter DATA_W, default 32, the result value width.
REQ-003 SHALL have clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have rst_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have rdy_in  input  1  global ready; when low, the CPU is paused.
REQ-006 SHALL have flush_pipline  input  1  pipeline flush; discards all pending results.
REQ-007 SHALL have alu_valid  input  1  ALU result offered this cycle.
REQ-008 SHALL have alu_rob_id  input  ROB_ID_W  tag of the ALU result.
REQ-009 SHALL have alu_value  input  DATA_W  ALU result value.
REQ-010 SHALL have alu_ready  output  1  ALU result accepted on this edge when alu_valid is also high.
REQ-011 SHALL have mem_valid, mem_rob_id, mem_value, mem_ready, identical in direction, width and meaning to the alu_* ports, for the memory unit.
REQ-012 SHALL have cdb_valid  output  1  broadcast valid on the common data bus.
REQ-013 SHALL have cdb_rob_id  output  ROB_ID_W  broadcast tag.
REQ-014 SHALL have cdb_value  output  DATA_W  broadcast value.
REQ-015 SHALL have cdb_src  output  1  source of the broadcast: 0 = ALU, 1 = MEM.

Function
REQ-016 SHALL hold one 2-entry FIFO per source (ALU, MEM), each entry storing {rob_id, value}, each FIFO with a 2-bit occupancy count 0..2.
REQ-017 SHALL drive x_ready = rdy_in AND (count_x != 2), a function of registered state and rdy_in only, with no dependence on x_valid or on the arbitration outcome.
REQ-018 SHALL push a source entry on an edge where x_valid AND x_ready AND NOT flush_pipline.
REQ-019 SHALL, on each edge with rdy_in high and no flush, grant at most one non-empty FIFO; the grant pops that FIFO head into the CDB output registers.
REQ-020 SHALL arbitrate round-robin via a last_grant bit: with only one FIFO non-empty, grant it; with both non-empty, grant the source not equal to last_grant; last_grant updates only on a grant.
REQ-021 SHALL, on a grant, set cdb_valid=1, cdb_rob_id/cdb_value = popped head, cdb_src = granted source; on an active edge with no grant, set cdb_valid=0 and hold the data outputs.
REQ-022 SHALL give minimum latency of 2 edges from acceptance to broadcast: entry pushed at edge k, cdb_valid high in the cycle after edge k+1; no bypass from inputs to CDB.
REQ-023 SHALL support push and pop on the same FIFO in one edge, leaving the count unchanged; FIFO order SHALL be strictly preserved.
REQ-024 SHALL sustain a throughput of one broadcast per cycle total, and one per cycle for a lone active source.
REQ-025 SHALL, while rdy_in is low (and no reset/flush), hold all state: FIFOs, counts, last_grant, and the cdb_* outputs (cdb_valid may therefore stay high across a pause); both ready outputs are 0.
REQ-026 SHALL, when flush_pipline is high on an edge, regardless of rdy_in: clear both counts, set cdb_valid=0, set last_grant=MEM (next tie grants ALU), and drop any same-cycle input offers.
REQ-027 SHALL ignore the stored contents of empty FIFO slots; the values of cdb_rob_id and cdb_value while cdb_valid=0 are don't-care but SHALL NOT be X after reset.

Reset
REQ-028 SHALL, when rst_in is high on an edge, regardless of rdy_in and flush_pipline: clear both counts and FIFO pointers, cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0, last_grant=MEM.
REQ-029 SHALL give rst_in priority over flush_pipline, and flush_pipline priority over rdy_in pause and normal operation.
REQ-030 SHALL hold alu_ready=mem_ready=rdy_in in the first cycle after reset (FIFOs empty).

Verification
REQ-031 Lone ALU: alu_valid with tag 3, value 0x11 at edge 1 -> cdb_valid=1, rob_id=3, value=0x11, src=0 after edge 2, cdb_valid=0 after edge 3.
REQ-032 Tie after reset: both FIFOs hold one entry (ALU tag 1, MEM tag 2) -> broadcasts in order tag 1 (src 0) then tag 2 (src 1); a second pair of entries again alternates ALU then MEM.
REQ-033 Backpressure: MEM offers every cycle while ALU keeps its FIFO non-empty -> MEM gets every other grant, mem_ready drops when count=2, and no tag is lost or duplicated (scoreboard).
REQ-034 Pause: with cdb_valid=1 showing tag 5, rdy_in=0 for 3 cycles -> outputs frozen at tag 5, ready=0, no push or pop; resume -> the next queued entry broadcasts on the first active edge.
REQ-035 Flush: both FIFOs full, plus a new alu_valid in the same cycle as flush_pipline=1 -> next cycle cdb_valid=0, counts=0, ready=1, and no flushed tag is ever broadcast.
REQ-036 Reset mid-operation: rst_in with full FIFOs and rdy_in=0 -> all outputs match REQ-028 values after that edge.
